// File: rtl/gon_sched_ctrl.sv
// gon_sched_ctrl: sequencer for the global output network (GON).
// Shifts PE column IDs into the X scan chains and row IDs into the Y scan
// chain, then walks row-major over a drain_rows x drain_cols window of PEs,
// steering tag_Y/tag_X and advancing one PE per GON_valid & GON_ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for cfg_start / drain_start
//   S_SCAN_X | shifting NUM_ROW*NUM_COL column IDs into the X chains
//   S_SCAN_Y | shifting NUM_COL row IDs (padding first) into the Y chain
//   S_DRAIN  | tags select the current PE, one PE per handshake
//   S_FIN    | one-cycle done pulse, tags parked at all-ones
module gon_sched_ctrl #(
    parameter int NUM_ROW  = 6,
    parameter int NUM_COL  = 8,
    parameter int XID_BITS = 5,
    parameter int YID_BITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic                           drain_start,
    input  logic [$clog2(NUM_ROW+1)-1:0]   drain_rows,
    input  logic [$clog2(NUM_COL+1)-1:0]   drain_cols,
    input  logic                           GON_valid,
    input  logic                           GON_ready,
    output logic                           set_XID,
    output logic [XID_BITS-1:0]            XID_scan_in,
    output logic                           set_YID,
    output logic [YID_BITS-1:0]            YID_scan_in,
    output logic [XID_BITS-1:0]            tag_X,
    output logic [YID_BITS-1:0]            tag_Y,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    drain_cnt
);

    localparam int RW  = $clog2(NUM_ROW + 1);
    localparam int CW  = $clog2(NUM_COL + 1);
    localparam int NPE = NUM_ROW * NUM_COL;
    localparam int KW  = $clog2(NPE + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN_X = 3'd1,
        S_SCAN_Y = 3'd2,
        S_DRAIN  = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [XID_BITS-1:0] x_q, x_d;
    logic [YID_BITS-1:0] y_q, y_d;
    logic [RW-1:0]       rows_q, rows_d;
    logic [CW-1:0]       cols_q, cols_d;
    logic [15:0]         drain_cnt_q, drain_cnt_d;

    logic                set_xid_q, set_xid_d;
    logic [XID_BITS-1:0] xid_scan_q, xid_scan_d;
    logic                set_yid_q, set_yid_d;
    logic [YID_BITS-1:0] yid_scan_q, yid_scan_d;
    logic [XID_BITS-1:0] tag_x_q, tag_x_d;
    logic [YID_BITS-1:0] tag_y_q, tag_y_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [RW-1:0]       rows_cl;
    logic [CW-1:0]       cols_cl;
    logic                hs;
    logic                x_last;
    logic                y_last;

    assign hs      = GON_valid & GON_ready;
    assign rows_cl = (drain_rows > RW'(NUM_ROW)) ? RW'(NUM_ROW) : drain_rows;
    assign cols_cl = (drain_cols > CW'(NUM_COL)) ? CW'(NUM_COL) : drain_cols;
    assign x_last  = (x_q == XID_BITS'(cols_q) - XID_BITS'(1));
    assign y_last  = (y_q == YID_BITS'(rows_q) - YID_BITS'(1));

    // State, walk counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            drain_cnt_q <= '0;
            set_xid_q   <= 1'b0;
            xid_scan_q  <= '0;
            set_yid_q   <= 1'b0;
            yid_scan_q  <= '0;
            tag_x_q     <= '1;
            tag_y_q     <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            drain_cnt_q <= drain_cnt_d;
            set_xid_q   <= set_xid_d;
            xid_scan_q  <= xid_scan_d;
            set_yid_q   <= set_yid_d;
            yid_scan_q  <= yid_scan_d;
            tag_x_q     <= tag_x_d;
            tag_y_q     <= tag_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state and walk counters; in SCAN_X, x counts columns downward.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_SCAN_X;
                    k_d     = '0;
                    x_d     = XID_BITS'(NUM_COL - 1);
                end else if (drain_start) begin
                    rows_d      = rows_cl;
                    cols_d      = cols_cl;
                    drain_cnt_d = '0;
                    x_d         = '0;
                    y_d         = '0;
                    if ((rows_cl == '0) || (cols_cl == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_SCAN_X: begin
                if (k_q == KW'(NPE - 1)) begin
                    state_d = S_SCAN_Y;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                    x_d = (x_q == '0) ? XID_BITS'(NUM_COL - 1) : x_q - XID_BITS'(1);
                end
            end
            S_SCAN_Y: begin
                if (k_q == KW'(NUM_COL - 1)) begin
                    state_d = S_FIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (hs) begin
                    if (drain_cnt_q != 16'hFFFF) begin
                        drain_cnt_d = drain_cnt_q + 16'd1;
                    end
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) begin
                            state_d = S_FIN;
                        end else begin
                            y_d = y_q + YID_BITS'(1);
                        end
                    end else begin
                        x_d = x_q + XID_BITS'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state.
    always_comb begin
        set_xid_d  = (state_d == S_SCAN_X);
        xid_scan_d = set_xid_d ? x_d : '0;
        set_yid_d  = (state_d == S_SCAN_Y);
        yid_scan_d = '0;
        if (set_yid_d) begin
            if (k_d < KW'(NUM_COL - NUM_ROW)) begin
                yid_scan_d = '1;
            end else begin
                yid_scan_d = YID_BITS'(NUM_COL - 1) - YID_BITS'(k_d);
            end
        end
        tag_x_d = (state_d == S_DRAIN) ? x_d : '1;
        tag_y_d = (state_d == S_DRAIN) ? y_d : '1;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FIN);
    end

    assign set_XID     = set_xid_q;
    assign XID_scan_in = xid_scan_q;
    assign set_YID     = set_yid_q;
    assign YID_scan_in = yid_scan_q;
    assign tag_X       = tag_x_q;
    assign tag_Y       = tag_y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign drain_cnt   = drain_cnt_q;

endmodule

// File: tb/tb_gon_sched_ctrl.sv
// Bench for gon_sched_ctrl: directed scenarios with literal expectations,
// then random traffic, all checked each cycle against a behavioural model.
module tb_gon_sched_ctrl;

    localparam int NR = 6;
    localparam int NC = 8;
    localparam int NSCAN = NR * NC + NC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       drain_start = 1'b0;
    logic [2:0] drain_rows = '0;
    logic [3:0] drain_cols = '0;
    logic       GON_valid = 1'b1;
    logic       GON_ready = 1'b1;
    logic       set_XID;
    logic [4:0] XID_scan_in;
    logic       set_YID;
    logic [3:0] YID_scan_in;
    logic [4:0] tag_X;
    logic [3:0] tag_Y;
    logic       busy;
    logic       done;
    logic [15:0] drain_cnt;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    gon_sched_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .drain_start(drain_start),
        .drain_rows(drain_rows), .drain_cols(drain_cols),
        .GON_valid(GON_valid), .GON_ready(GON_ready),
        .set_XID(set_XID), .XID_scan_in(XID_scan_in),
        .set_YID(set_YID), .YID_scan_in(YID_scan_in),
        .tag_X(tag_X), .tag_Y(tag_Y), .busy(busy), .done(done),
        .drain_cnt(drain_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 scanning (p = position in the whole X+Y shift),
    // 2 draining (i = row-major PE index), 3 finishing.
    int m_mode = 0, m_p = 0, m_i = 0, m_r = 0, m_c = 0, m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_p <= 0; m_i <= 0; m_cnt <= 0; m_r <= 0; m_c <= 0;
        end else begin
            case (m_mode)
                0: if (cfg_start) begin
                       m_mode <= 1; m_p <= 0;
                   end else if (drain_start) begin
                       int r, c;
                       r = (int'(drain_rows) > NR) ? NR : int'(drain_rows);
                       c = (int'(drain_cols) > NC) ? NC : int'(drain_cols);
                       m_r <= r; m_c <= c; m_cnt <= 0; m_i <= 0;
                       m_mode <= (r * c == 0) ? 3 : 2;
                   end
                1: begin
                       m_p <= m_p + 1;
                       if (m_p + 1 == NSCAN) m_mode <= 3;
                   end
                2: if (GON_valid && GON_ready) begin
                       m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                       m_i <= m_i + 1;
                       if (m_i + 1 == m_r * m_c) m_mode <= 3;
                   end
                default: m_mode <= 0;
            endcase
        end
    end

    logic       e_sx, e_sy;
    logic [4:0] e_xd, e_tx;
    logic [3:0] e_yd, e_ty;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            e_sx = (m_mode == 1) && (m_p < NR * NC);
            e_sy = (m_mode == 1) && (m_p >= NR * NC);
            e_xd = e_sx ? 5'(NC - 1 - (m_p % NC)) : 5'd0;
            e_yd = 4'd0;
            if (e_sy) e_yd = (m_p - NR * NC < NC - NR) ? 4'hF : 4'(NC - 1 - (m_p - NR * NC));
            e_tx = (m_mode == 2) ? 5'(m_i % m_c) : 5'h1F;
            e_ty = (m_mode == 2) ? 4'(m_i / m_c) : 4'hF;
            chk("scan_outputs", 32'({set_XID, XID_scan_in, set_YID, YID_scan_in}),
                32'({e_sx, e_xd, e_sy, e_yd}));
            chk("tags", 32'({tag_Y, tag_X}), 32'({e_ty, e_tx}));
            chk("status", 32'({busy, done, drain_cnt}),
                32'({m_mode != 0, m_mode == 3, 16'(m_cnt)}));
        end
    end

    task automatic pulse_cfg();
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
    endtask

    task automatic pulse_drain(input int r, input int c);
        @(negedge clk); drain_start = 1'b1; drain_rows = 3'(r); drain_cols = 4'(c);
        @(negedge clk); drain_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk); n++;
        end
        if (busy) chk({nm, "_timeout"}, 32'(busy), 32'd0);
    endtask

    int bc, xc, yc, dc, dcyc, tagc, t11, stall, nseq;
    logic [31:0] ypack;
    logic [4:0] xd [0:63];
    int seq [0:15];
    int exp_seq [0:5];

    initial begin
        exp_seq[0] = 'h00; exp_seq[1] = 'h01; exp_seq[2] = 'h02;
        exp_seq[3] = 'h10; exp_seq[4] = 'h11; exp_seq[5] = 'h12;

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_tags", 32'({tag_Y, tag_X}), 32'h1FF);
        chk("reset_status", 32'({busy, done, set_XID, set_YID, drain_cnt}), 32'd0);
        @(negedge clk); rst = 1'b0;

        // ID scan with default geometry
        pulse_cfg();
        bc = 0; xc = 0; yc = 0; dc = 0; dcyc = -1; ypack = '0;
        for (int n = 0; n < 80; n++) begin
            if (busy) bc++;
            if (set_XID) begin
                if (xc < 64) xd[xc] = XID_scan_in;
                xc++;
            end
            if (set_YID) begin ypack = {ypack[27:0], YID_scan_in}; yc++; end
            if (done) begin dc++; dcyc = n; end
            @(negedge clk);
        end
        chk("scan_x_len", 32'(xc), 32'd48);
        chk("scan_y_len", 32'(yc), 32'd8);
        chk("scan_busy_len", 32'(bc), 32'd57);
        chk("scan_done_count", 32'(dc), 32'd1);
        chk("scan_done_cycle", 32'(dcyc), 32'd56);
        chk("scan_x_first", 32'(xd[0]), 32'd7);
        chk("scan_x_9", 32'(xd[9]), 32'd6);
        chk("scan_x_last", 32'(xd[47]), 32'd0);
        chk("scan_y_words", ypack, 32'hFF543210);

        // 2x3 drain, always ready
        GON_valid = 1'b1; GON_ready = 1'b1;
        pulse_drain(2, 3);
        nseq = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (nseq < 16) seq[nseq] = int'(tag_Y) * 16 + int'(tag_X);
            nseq++;
            @(negedge clk);
        end
        chk("drain_len", 32'(nseq), 32'd6);
        for (int j = 0; j < 6; j++) chk("drain_tag", 32'(seq[j]), 32'(exp_seq[j]));
        chk("drain_done", 32'(done), 32'd1);
        chk("drain_cnt_6", 32'(drain_cnt), 32'd6);
        @(negedge clk);

        // backpressure at (1,1): 5 stalled cycles plus the handshake cycle
        pulse_drain(2, 3);
        t11 = 0; stall = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (tag_Y == 4'd1 && tag_X == 5'd1) begin
                t11++;
                if (stall < 5) begin GON_ready = 1'b0; stall++; end
                else GON_ready = 1'b1;
            end else begin
                GON_ready = 1'b1;
            end
            @(negedge clk);
        end
        GON_ready = 1'b1;
        chk("stall_tag_cycles", 32'(t11), 32'd6);
        chk("stall_cnt", 32'(drain_cnt), 32'd6);
        @(negedge clk);

        // empty window
        pulse_drain(0, 4);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_cnt", 32'(drain_cnt), 32'd0);
        chk("empty_tags", 32'({tag_Y, tag_X}), 32'h1FF);
        @(negedge clk);
        chk("empty_after", 32'({busy, done}), 32'd0);

        // simultaneous starts: scan wins; drain_start during scan is dropped
        @(negedge clk);
        cfg_start = 1'b1; drain_start = 1'b1; drain_rows = 3'd2; drain_cols = 4'd3;
        @(negedge clk);
        cfg_start = 1'b0; drain_start = 1'b0;
        bc = 0; tagc = 0;
        for (int n = 0; n < 80; n++) begin
            if (busy) bc++;
            if (tag_X != 5'h1F) tagc++;
            drain_start = (n == 10);
            @(negedge clk);
        end
        chk("both_busy_len", 32'(bc), 32'd57);
        chk("both_no_drain", 32'(tagc), 32'd0);

        // reset in the middle of SCAN_X
        pulse_cfg();
        repeat (20) @(negedge clk);
        chk("pre_rst_k20", 32'({set_XID, XID_scan_in}), 32'({1'b1, 5'd3}));
        #2 rst = 1'b1;
        #1;
        chk("rst_scan", 32'({set_XID, XID_scan_in, set_YID, YID_scan_in}), 32'd0);
        chk("rst_status", 32'({busy, done, drain_cnt}), 32'd0);
        chk("rst_tags", 32'({tag_Y, tag_X}), 32'h1FF);
        @(negedge clk); rst = 1'b0;
        pulse_cfg();
        chk("restart_k0", 32'({set_XID, XID_scan_in}), 32'({1'b1, 5'd7}));
        wait_idle("restart", 100);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            cfg_start   = ($urandom_range(0, 79) == 0);
            drain_start = ($urandom_range(0, 5) == 0);
            drain_rows  = 3'($urandom_range(0, 7));
            drain_cols  = 4'($urandom_range(0, 15));
            GON_valid   = ($urandom_range(0, 3) != 0);
            GON_ready   = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        cfg_start = 1'b0; drain_start = 1'b0; GON_valid = 1'b1; GON_ready = 1'b1;
        wait_idle("random_end", 200);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
